decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 124 ++++++++++++
 tb/tb_decode_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: circular buffer between a dual-issue decoder and issue stage.
// Accepts up to two entries per cycle and presents the two oldest entries
// combinationally. Protocol violations latch a sticky err flag.
module decode_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [WIDTH-1:0]         in_data0,
  input  logic [WIDTH-1:0]         in_data1,
  output logic                     in_ready,
  output logic [1:0]               out_valid,
  output logic [WIDTH-1:0]         out_data0,
  output logic [WIDTH-1:0]         out_data1,
  input  logic [1:0]               num_read,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic          push_legal;
  logic          push_ok;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_req;
  logic [CW-1:0] pop_n;
  logic          proto_err;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;

  // Pointer successors wrap naturally because DEPTH is a power of two.
  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Readiness depends only on registered occupancy, never on same-cycle pops.
  assign in_ready = (count_q <= CW'(DEPTH - 2));

  // Push/pop sizing and protocol-error detection.
  always_comb begin
    push_legal = (in_valid == 2'b01) || (in_valid == 2'b11);
    push_ok    = in_ready && push_legal;
    push_n     = '0;
    if (push_ok) begin
      push_n = (in_valid == 2'b11) ? CW'(2) : CW'(1);
    end
    pop_req = '0;
    if (num_read == 2'b01) begin
      pop_req = CW'(1);
    end else if (num_read == 2'b11) begin
      pop_req = CW'(2);
    end
    // Over-requesting is legal: issue may ask for more than is present.
    pop_n     = (pop_req > count_q) ? count_q : pop_req;
    proto_err = (in_valid == 2'b10) || (num_read == 2'b10) ||
                ((in_valid != 2'b00) && !in_ready);
  end

  // Next-state for pointers, occupancy and error; flush overrides everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      head_d  = head_q + AW'(pop_n);
      tail_d  = tail_q + AW'(push_n);
      count_d = count_q + push_n - pop_n;
      err_d   = err_q | proto_err;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage is not reset; outputs are zero-forced when invalid instead.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) begin
      mem[tail_q] <= in_data0;
      if (in_valid[1]) begin
        mem[tail_p1] <= in_data1;
      end
    end
  end

  // Zero-latency view of the two oldest entries.
  always_comb begin
    out_valid[0] = (count_q != '0);
    out_valid[1] = (count_q >= CW'(2));
    out_data0    = out_valid[0] ? mem[head_q]  : '0;
    out_data1    = out_valid[1] ? mem[head_p1] : '0;
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue with a reference queue as scoreboard.
module tb_decode_queue;

  localparam int DEPTH = 8;
  localparam int WIDTH = 64;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [1:0]       in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [1:0]       num_read;
  logic [3:0]       count;
  logic             err;

  int errors = 0;
  int checks = 0;

  // Reference: entries in expected departure order, plus expected err.
  logic [WIDTH-1:0] sb[$];
  logic             m_err;

  decode_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .num_read  (num_read),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the reference model.
  task automatic check_outputs(input string tag);
    int sz;
    logic [WIDTH-1:0] e0, e1;
    sz = sb.size();
    e0 = (sz >= 1) ? sb[0] : '0;
    e1 = (sz >= 2) ? sb[1] : '0;
    chk({tag, ".count"},     64'(count),     64'(sz));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'({sz >= 2, sz >= 1}));
    chk({tag, ".out_data0"}, out_data0,      e0);
    chk({tag, ".out_data1"}, out_data1,      e1);
    chk({tag, ".in_ready"},  64'(in_ready),  64'(sz <= DEPTH - 2));
    chk({tag, ".err"},       64'(err),       64'(m_err));
    $display("[%0t] %s v=%b nr=%b fl=%b count=%0d out_valid=%b err=%b",
             $time, tag, in_valid, num_read, flush, count, out_valid, err);
  endtask

  // One clock: drive inputs, check pre-edge outputs, apply edge to model.
  task automatic cyc(input string tag, input logic [1:0] v, input logic [1:0] nr,
                     input logic fl);
    int sz;
    int req;
    int npop;
    bit rdy;
    in_valid = v;
    num_read = nr;
    flush    = fl;
    in_data0 = {$urandom, $urandom};
    in_data1 = {$urandom, $urandom};
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (fl) begin
      sb.delete();
      m_err = 1'b0;
    end else begin
      sz  = sb.size();
      rdy = (sz <= DEPTH - 2);
      if (v == 2'b10 || nr == 2'b10 || (v != 2'b00 && !rdy)) m_err = 1'b1;
      req  = (nr == 2'b01) ? 1 : (nr == 2'b11) ? 2 : 0;
      npop = (req < sz) ? req : sz;
      for (int i = 0; i < npop; i++) void'(sb.pop_front());
      if (rdy && (v == 2'b01 || v == 2'b11)) sb.push_back(in_data0);
      if (rdy && v == 2'b11) sb.push_back(in_data1);
    end
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 2'b00;
    num_read = 2'b00;
    in_data0 = '0;
    in_data1 = '0;
    m_err    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, then two-entry push visible one cycle later.
    cyc("reset",     2'b00, 2'b00, 1'b0);
    cyc("push_ab",   2'b11, 2'b00, 1'b0);
    cyc("see_ab",    2'b00, 2'b00, 1'b0);

    // Fill to 7, then a push while not ready is dropped and sets err.
    cyc("fill1",     2'b11, 2'b00, 1'b0);
    cyc("fill2",     2'b11, 2'b00, 1'b0);
    cyc("fill3",     2'b01, 2'b00, 1'b0);
    cyc("push_full", 2'b01, 2'b00, 1'b0);
    cyc("full_hold", 2'b00, 2'b00, 1'b0);

    // Drain with over-request at the tail end; head ends at index 7.
    cyc("drain1",    2'b00, 2'b11, 1'b0);
    cyc("drain2",    2'b00, 2'b11, 1'b0);
    cyc("drain3",    2'b00, 2'b11, 1'b0);
    cyc("drain4",    2'b00, 2'b11, 1'b0);
    cyc("over_rd",   2'b00, 2'b11, 1'b0);

    // Straddling push at 7->0, then straddling pop leaves head at 1.
    cyc("wrap_push", 2'b11, 2'b00, 1'b0);
    cyc("wrap_see",  2'b00, 2'b00, 1'b0);
    cyc("wrap_pop",  2'b00, 2'b11, 1'b0);
    cyc("wrap_empty",2'b00, 2'b00, 1'b0);
    cyc("flush1",    2'b00, 2'b00, 1'b1);

    // One entry present, pop two while pushing two: saturating pop, no err.
    cyc("push_x",    2'b01, 2'b00, 1'b0);
    cyc("pop_push",  2'b11, 2'b11, 1'b0);
    cyc("see_yz",    2'b00, 2'b00, 1'b0);

    // Illegal encodings set sticky err.
    cyc("bad_valid", 2'b10, 2'b00, 1'b0);
    cyc("err_hold",  2'b00, 2'b01, 1'b0);
    cyc("flush2",    2'b00, 2'b00, 1'b1);
    cyc("push_pre",  2'b11, 2'b00, 1'b0);
    cyc("bad_read",  2'b00, 2'b10, 1'b0);
    cyc("err_hold2", 2'b00, 2'b00, 1'b0);
    cyc("flush3",    2'b00, 2'b00, 1'b1);

    // Flush priority over same-cycle push and pop at count 5.
    cyc("f5_a",      2'b11, 2'b00, 1'b0);
    cyc("f5_b",      2'b11, 2'b00, 1'b0);
    cyc("f5_c",      2'b01, 2'b00, 1'b0);
    cyc("f5_flush",  2'b11, 2'b11, 1'b1);
    cyc("f5_after",  2'b00, 2'b00, 1'b0);

    // Asynchronous reset between edges with count 4.
    cyc("r4_a",      2'b11, 2'b00, 1'b0);
    cyc("r4_b",      2'b11, 2'b00, 1'b0);
    in_valid = 2'b00;
    num_read = 2'b00;
    #1;
    check_outputs("r4_pre");
    #2;
    rst = 1'b1;
    sb.delete();
    m_err = 1'b0;
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst_push", 2'b01, 2'b00, 1'b0);
    cyc("post_rst_see",  2'b00, 2'b00, 1'b0);
    cyc("flush4",        2'b00, 2'b00, 1'b1);

    // Mixed legal traffic to exercise repeated wrap-around.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] v;
      logic [1:0] nr;
      v  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
      if ($urandom_range(0, 3) == 0) v = 2'b00;
      nr = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
      if ($urandom_range(0, 3) == 0) nr = 2'b00;
      if (sb.size() > DEPTH - 2) v = 2'b00;
      cyc("mix", v, nr, 1'b0);
    end
    cyc("mix_end", 2'b00, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
